// File: rtl/forward_scoreboard.sv
// Operand bypass resolution plus a per-physical-register scoreboard of in-flight
// producers, with latency countdowns so multi-cycle loads stall their consumers.
module forward_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int PREG_W         = 6,
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD        = 3,
  parameter int LOAD_LAT       = 2,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic [NUM_SRC*PREG_W-1:0]     src_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rf_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*PREG_W-1:0]     fwd_addr,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data,
  input  logic                          issue_fire,
  input  logic [PREG_W-1:0]             issue_rd,
  input  logic                          issue_uses_rw,
  input  logic                          issue_is_load,
  input  logic                          wb_valid,
  input  logic [PREG_W-1:0]             wb_addr,
  input  logic                          flush,
  output logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          o_hazard,
  output logic [PREG_W:0]               pending_count
);

  localparam int NREG  = 1 << PREG_W;
  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  logic [NREG-1:0]             pending_r;
  logic [NREG-1:0][CNT_W-1:0]  cnt_r;
  logic [NREG-1:0]             pending_nxt_s;
  logic [NREG-1:0][CNT_W-1:0]  cnt_nxt_s;
  logic [PREG_W:0]             count_nxt_s;
  logic                        issue_ok_s;

  assign issue_ok_s = issue_fire & issue_uses_rw &
                      ~((ZERO_HARDWIRED != 0) & (issue_rd == '0));

  // Next-state scoreboard: flush beats issue, issue beats writeback and countdown.
  always_comb begin
    pending_nxt_s = pending_r;
    cnt_nxt_s     = cnt_r;
    count_nxt_s   = '0;
    for (int p = 0; p < NREG; p++) begin
      if (flush) begin
        pending_nxt_s[p] = 1'b0;
        cnt_nxt_s[p]     = '0;
      end else if (issue_ok_s && (issue_rd == PREG_W'(p))) begin
        pending_nxt_s[p] = 1'b1;
        cnt_nxt_s[p]     = issue_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(1);
      end else if (wb_valid && (wb_addr == PREG_W'(p))) begin
        pending_nxt_s[p] = 1'b0;
        cnt_nxt_s[p]     = '0;
      end else if (pending_r[p] && (cnt_r[p] != '0)) begin
        cnt_nxt_s[p]     = cnt_r[p] - CNT_W'(1);
      end else begin
        cnt_nxt_s[p]     = cnt_r[p];
      end
      count_nxt_s = count_nxt_s + (PREG_W+1)'(pending_nxt_s[p]);
    end
  end

  // Scoreboard state and registered occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r     <= '0;
      cnt_r         <= '0;
      pending_count <= '0;
    end else begin
      pending_r     <= pending_nxt_s;
      cnt_r         <= cnt_nxt_s;
      pending_count <= count_nxt_s;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [PREG_W-1:0]     addr_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] fdata_s;
    logic                  is_zero_s;
    logic                  wb_hit_s;
    logic                  due_s;

    assign addr_s    = src_addr[i*PREG_W +: PREG_W];
    assign is_zero_s = (ZERO_HARDWIRED != 0) && (addr_s == '0);
    assign wb_hit_s  = wb_valid && (wb_addr == addr_s);
    // A count of 1 reaches zero at the end of this cycle: the producer's result is on a bypass port now.
    assign due_s     = (cnt_r[addr_s] <= CNT_W'(1));

    // Walk oldest to youngest so the youngest matching stage ends up selected.
    always_comb begin
      hit_s   = 1'b0;
      fdata_s = src_rf_data[i*DATA_WIDTH +: DATA_WIDTH];
      for (int j = NUM_FWD - 1; j >= 0; j--) begin
        if (fwd_valid[j] && (fwd_addr[j*PREG_W +: PREG_W] == addr_s)) begin
          hit_s   = 1'b1;
          fdata_s = fwd_data[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          hit_s   = hit_s;
        end
      end
    end

    assign src_data[i*DATA_WIDTH +: DATA_WIDTH] = is_zero_s ? '0 : fdata_s;
    assign src_ready[i] = ~src_used[i] | ~pending_r[addr_s] | (due_s & (hit_s | wb_hit_s));
  end

  assign o_hazard = |(~src_ready);

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed and randomized checks of forward_scoreboard against a cycle-stamp
// availability model (each pending preg records the cycle its data becomes bypassable).
module tb_forward_scoreboard;
  localparam int DW = 32, PW = 6, NS = 2, NF = 3, LL = 2, NR = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NS-1:0]      src_used = '0;
  logic [NS*PW-1:0]   src_addr = '0;
  logic [NS*DW-1:0]   src_rf_data = '0;
  logic [NF-1:0]      fwd_valid = '0;
  logic [NF*PW-1:0]   fwd_addr = '0;
  logic [NF*DW-1:0]   fwd_data = '0;
  logic               issue_fire = 1'b0, issue_uses_rw = 1'b0, issue_is_load = 1'b0;
  logic [PW-1:0]      issue_rd = '0, wb_addr = '0;
  logic               wb_valid = 1'b0, flush = 1'b0;
  logic [NS*DW-1:0]   src_data;
  logic [NS-1:0]      src_ready;
  logic               o_hazard;
  logic [PW:0]        pending_count;

  forward_scoreboard #(.DATA_WIDTH(DW), .PREG_W(PW), .NUM_SRC(NS), .NUM_FWD(NF),
                       .LOAD_LAT(LL), .ZERO_HARDWIRED(1)) dut (
    .clk(clk), .rst_n(rst_n), .src_used(src_used), .src_addr(src_addr),
    .src_rf_data(src_rf_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .issue_fire(issue_fire), .issue_rd(issue_rd),
    .issue_uses_rw(issue_uses_rw), .issue_is_load(issue_is_load),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .src_data(src_data),
    .src_ready(src_ready), .o_hazard(o_hazard), .pending_count(pending_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit     m_pend[NR];
  longint m_avail[NR];
  longint cyc = 0;

  function automatic void model_clear();
    for (int p = 0; p < NR; p++) begin
      m_pend[p]  = 1'b0;
      m_avail[p] = 0;
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int p = 0; p < NR; p++) c += int'(m_pend[p]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_data(int i);
    int a = int'(src_addr[i*PW +: PW]);
    if (a == 0) return '0;
    for (int j = 0; j < NF; j++)
      if (fwd_valid[j] && int'(fwd_addr[j*PW +: PW]) == a) return fwd_data[j*DW +: DW];
    return src_rf_data[i*DW +: DW];
  endfunction

  function automatic bit exp_ready(int i);
    int a = int'(src_addr[i*PW +: PW]);
    bit seen = wb_valid && int'(wb_addr) == a;
    for (int j = 0; j < NF; j++)
      if (fwd_valid[j] && int'(fwd_addr[j*PW +: PW]) == a) seen = 1'b1;
    if (!src_used[i] || !m_pend[a]) return 1'b1;
    return (cyc >= m_avail[a]) && seen;
  endfunction

  task automatic idle();
    src_used = '0; src_addr = '0; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    issue_fire = 1'b0; issue_rd = '0; issue_uses_rw = 1'b0; issue_is_load = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
  endtask

  task automatic set_src(int i, bit used, int addr, logic [DW-1:0] rf);
    src_used[i] = used;
    src_addr[i*PW +: PW] = PW'(addr);
    src_rf_data[i*DW +: DW] = rf;
  endtask

  task automatic set_fwd(int j, bit v, int addr, logic [DW-1:0] d);
    fwd_valid[j] = v;
    fwd_addr[j*PW +: PW] = PW'(addr);
    fwd_data[j*DW +: DW] = d;
  endtask

  task automatic issue(int rd, bit load);
    issue_fire = 1'b1; issue_uses_rw = 1'b1; issue_rd = PW'(rd); issue_is_load = load;
  endtask

  // Advance one clock, applying the same cycle's inputs to the model.
  task automatic tick();
    if (wb_valid) m_pend[wb_addr] = 1'b0;
    if (issue_fire && issue_uses_rw && issue_rd != '0) begin
      m_pend[issue_rd]  = 1'b1;
      m_avail[issue_rd] = cyc + (issue_is_load ? LL : 1);
    end
    if (flush) model_clear();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++; if (pending_count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", pending_count); end
    checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", o_hazard); end
    @(posedge clk); #1; rst_n = 1'b1;
    issue(5, 1'b1);
    tick();
    idle();
    set_src(0, 1'b1, 5, 32'h5555_0000);
    #1;
    checks++; if (o_hazard !== 1'b1) begin errors++; $display("FAIL load_pending_hazard got %b exp 1", o_hazard); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (pending_count !== 7'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", pending_count); end
    checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL midrst_hazard got %b exp 0", o_hazard); end
    checks++; if (src_data[DW-1:0] !== 32'h5555_0000) begin errors++; $display("FAIL midrst_data got %h exp 55550000", src_data[DW-1:0]); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    idle(); issue(7, 1'b0); tick();
    idle(); set_src(0, 1'b1, 7, 32'h0); set_fwd(0, 1'b1, 7, 32'hDEAD_BEEF);
    #1;
    checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL alu_ready got %b exp 1", src_ready[0]); end
    checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL alu_hazard got %b exp 0", o_hazard); end
    checks++; if (src_data[DW-1:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", src_data[DW-1:0]); end
    checks++; if (pending_count !== 7'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", pending_count); end
    set_fwd(0, 1'b0, 7, 32'hDEAD_BEEF);
    #1;
    checks++; if (o_hazard !== 1'b1) begin errors++; $display("FAIL alu_nofwd_hazard got %b exp 1", o_hazard); end
    idle(); wb_valid = 1'b1; wb_addr = 6'd7; tick(); idle();
  endtask

  task automatic test_load_use();
    idle(); issue(9, 1'b1); tick();
    idle(); set_src(1, 1'b1, 9, 32'h0000_FFFF);
    #1;
    checks++; if (o_hazard !== 1'b1) begin errors++; $display("FAIL load_stall got %b exp 1", o_hazard); end
    tick();
    set_fwd(1, 1'b1, 9, 32'h0000_1234);
    #1;
    checks++; if (o_hazard !== 1'b0) begin errors++; $display("FAIL load_release got %b exp 0", o_hazard); end
    checks++; if (src_data[2*DW-1:DW] !== 32'h0000_1234) begin errors++; $display("FAIL load_data got %h exp 00001234", src_data[2*DW-1:DW]); end
    idle(); wb_valid = 1'b1; wb_addr = 6'd9; tick(); idle();
  endtask

  task automatic test_priority();
    idle(); set_src(0, 1'b1, 3, 32'h0);
    set_fwd(0, 1'b1, 3, 32'hA); set_fwd(1, 1'b1, 3, 32'hB); set_fwd(2, 1'b1, 3, 32'hC);
    #1;
    checks++; if (src_data[DW-1:0] !== 32'hA) begin errors++; $display("FAIL prio_all got %h exp a", src_data[DW-1:0]); end
    fwd_valid[0] = 1'b0;
    #1;
    checks++; if (src_data[DW-1:0] !== 32'hB) begin errors++; $display("FAIL prio_no0 got %h exp b", src_data[DW-1:0]); end
    fwd_valid[1] = 1'b0;
    #1;
    checks++; if (src_data[DW-1:0] !== 32'hC) begin errors++; $display("FAIL prio_only2 got %h exp c", src_data[DW-1:0]); end
    idle();
  endtask

  task automatic test_simultaneous();
    idle(); issue(4, 1'b0); tick();
    checks++; if (pending_count !== 7'd1) begin errors++; $display("FAIL sim_first got %0d exp 1", pending_count); end
    issue(4, 1'b0); wb_valid = 1'b1; wb_addr = 6'd4; tick();
    checks++; if (pending_count !== 7'd1) begin errors++; $display("FAIL sim_wb_issue got %0d exp 1", pending_count); end
    idle(); set_src(0, 1'b1, 4, 32'h0);
    #1;
    checks++; if (o_hazard !== 1'b1) begin errors++; $display("FAIL sim_still_pending got %b exp 1", o_hazard); end
    idle(); issue(5, 1'b1); flush = 1'b1; tick();
    checks++; if (pending_count !== 7'd0) begin errors++; $display("FAIL flush_issue got %0d exp 0", pending_count); end
    idle();
  endtask

  task automatic test_zero_reg();
    idle(); issue(0, 1'b1); tick();
    checks++; if (pending_count !== 7'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", pending_count); end
    idle(); set_src(0, 1'b1, 0, 32'hABCD); set_fwd(0, 1'b1, 0, 32'h77);
    #1;
    checks++; if (src_data[DW-1:0] !== 32'h0) begin errors++; $display("FAIL zero_data got %h exp 0", src_data[DW-1:0]); end
    checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", src_ready[0]); end
    idle();
  endtask

  task automatic test_random();
    bit exp_hz;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        set_src(i, 1'($urandom), int'($urandom_range(0, 7)), $urandom);
      for (int j = 0; j < NF; j++)
        set_fwd(j, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), $urandom);
      issue_fire    = ($urandom_range(0, 2) != 0);
      issue_rd      = PW'($urandom_range(0, 7));
      issue_uses_rw = 1'($urandom);
      issue_is_load = 1'($urandom);
      wb_valid      = ($urandom_range(0, 3) == 0);
      wb_addr       = PW'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 40) == 0);
      #1;
      exp_hz = 1'b0;
      for (int i = 0; i < NS; i++) begin
        checks++;
        if (src_data[i*DW +: DW] !== exp_data(i)) begin
          errors++; $display("FAIL rnd_data[%0d] cyc %0d got %h exp %h", i, cyc, src_data[i*DW +: DW], exp_data(i));
        end
        checks++;
        if (src_ready[i] !== exp_ready(i)) begin
          errors++; $display("FAIL rnd_ready[%0d] cyc %0d got %b exp %b", i, cyc, src_ready[i], exp_ready(i));
        end
        exp_hz = exp_hz | ~exp_ready(i);
      end
      checks++;
      if (o_hazard !== exp_hz) begin errors++; $display("FAIL rnd_hazard cyc %0d got %b exp %b", cyc, o_hazard, exp_hz); end
      checks++;
      if (int'(pending_count) != m_count()) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, pending_count, m_count()); end
      tick();
    end
    idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_back_to_back();
    test_load_use();
    test_priority();
    test_simultaneous();
    test_zero_reg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
